dram_port_arbiter: RTL and testbench

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

---
 rtl/dram_port_arbiter.sv | 101 ++++++++++
 tb/tb_dram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: two-requester (cache, DMA) arbiter in front of a DRAM controller
// Ports: Clock/Reset_H; Req0_*/Req1_* requester buses (AS/WE/UDS/LDS active low, address, data);
// ReqN_Dtack_L/ReqN_BErr_L per-requester ack/abort; *_Dram outputs and DtackFromDram_L to the
// DRAM controller; Grant one-hot owner; ArbState debug state.
module dram_port_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic        Req0_AS_L,
  input  logic        Req0_WE_L,
  input  logic        Req0_UDS_L,
  input  logic        Req0_LDS_L,
  input  logic [31:0] Req0_Address,
  input  logic [15:0] Req0_Data,
  input  logic        Req1_AS_L,
  input  logic        Req1_WE_L,
  input  logic        Req1_UDS_L,
  input  logic        Req1_LDS_L,
  input  logic [31:0] Req1_Address,
  input  logic [15:0] Req1_Data,
  output logic        Req0_Dtack_L,
  output logic        Req1_Dtack_L,
  output logic        Req0_BErr_L,
  output logic        Req1_BErr_L,
  output logic        AS_Dram_L,
  output logic        WE_Dram_L,
  output logic        UDS_Dram_L,
  output logic        LDS_Dram_L,
  output logic [31:0] Address_Dram,
  output logic [15:0] Data_Dram,
  input  logic        DtackFromDram_L,
  output logic [1:0]  Grant,
  output logic [2:0]  ArbState
);
  localparam int HW = ($clog2(MAX_HOLD + 1) > 3) ? $clog2(MAX_HOLD + 1) : 3;
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  typedef enum logic [2:0] {S_IDLE, S_OWN0, S_OWN1, S_WAIT, S_GAP} state_t;
  state_t          r_state;
  logic            r_owner;
  logic            r_berr;
  logic [HW-1:0]   r_hold;
  logic [TW-1:0]   r_tmo;
  logic            w_own, w_sel, w_busy, w_as, w_ack, w_exp, w_dtack, w_berr;
  assign w_own  = (r_state == S_OWN0) || (r_state == S_OWN1);
  assign w_sel  = (r_state == S_OWN1) || ((r_state == S_WAIT) && r_owner);
  assign w_busy = w_own || (r_state == S_WAIT);
  assign w_as   = w_sel ? Req1_AS_L : Req0_AS_L;
  assign w_ack  = w_own && !w_as && !DtackFromDram_L;
  // r_tmo counts completed owner cycles, so the abort lands on the TIMEOUT-th cycle
  assign w_exp  = w_own && !w_as && DtackFromDram_L && (r_tmo == TW'(TIMEOUT - 1));
  assign w_dtack = w_ack || ((r_state == S_WAIT) && !r_berr);
  assign w_berr  = w_exp || ((r_state == S_WAIT) && r_berr);
  assign Grant        = w_busy ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
  assign Req0_Dtack_L = !(w_dtack && !w_sel);
  assign Req1_Dtack_L = !(w_dtack && w_sel);
  assign Req0_BErr_L  = !(w_berr && !w_sel);
  assign Req1_BErr_L  = !(w_berr && w_sel);
  assign AS_Dram_L    = !((w_own && !w_as && !w_exp) || ((r_state == S_WAIT) && !r_berr));
  assign WE_Dram_L    = w_busy ? (w_sel ? Req1_WE_L : Req0_WE_L) : 1'b1;
  assign UDS_Dram_L   = w_busy ? (w_sel ? Req1_UDS_L : Req0_UDS_L) : 1'b1;
  assign LDS_Dram_L   = w_busy ? (w_sel ? Req1_LDS_L : Req0_LDS_L) : 1'b1;
  assign Address_Dram = (w_busy && w_sel) ? Req1_Address : Req0_Address;
  assign Data_Dram    = (w_busy && w_sel) ? Req1_Data : Req0_Data;
  assign ArbState     = r_state;
  always_ff @(posedge Clock or posedge Reset_H)
    if (Reset_H) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_berr  <= 1'b0;
      r_hold  <= '0;
      r_tmo   <= '0;
    end else
      case (r_state)
        S_IDLE:
          // hold never exceeds MAX_HOLD: at MAX_HOLD a waiting req1 wins instead
          if (!Req0_AS_L && (Req1_AS_L || r_hold != HW'(MAX_HOLD))) begin
            r_state <= S_OWN0;
            r_tmo   <= '0;
            r_hold  <= Req1_AS_L ? '0 : r_hold + 1'b1;
          end else if (!Req1_AS_L) begin
            r_state <= S_OWN1;
            r_tmo   <= '0;
            r_hold  <= '0;
          end
        S_OWN0, S_OWN1: begin
          r_owner <= w_sel;
          if (w_as) r_state <= S_GAP;
          else if (!DtackFromDram_L) begin
            r_state <= S_WAIT;
            r_berr  <= 1'b0;
          end else if (w_exp) begin
            r_state <= S_WAIT;
            r_berr  <= 1'b1;
          end else r_tmo <= r_tmo + 1'b1;
        end
        S_WAIT:  r_state <= w_as ? S_GAP : S_WAIT;
        default: r_state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed bench with a transaction-level reference model
module tb_dram_port_arbiter;
  localparam int MAX_HOLD = 4;
  localparam int TIMEOUT  = 255;
  localparam int P_FREE = 0, P_ACC = 1, P_DONE = 2, P_ABT = 3, P_GAP = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        man0 = 1'b1, man1 = 1'b1, en0 = 1'b0, en1 = 1'b0, ag0 = 1'b1, ag1 = 1'b1;
  logic        seen0 = 1'b0, seen1 = 1'b0;
  logic        Req0_AS_L, Req1_AS_L;
  logic        Req0_WE_L = 1'b1, Req0_UDS_L = 1'b0, Req0_LDS_L = 1'b0;
  logic        Req1_WE_L = 1'b1, Req1_UDS_L = 1'b0, Req1_LDS_L = 1'b0;
  logic [31:0] Req0_Address = 32'h0000_0100, Req1_Address = 32'h0000_0200;
  logic [15:0] Req0_Data = 16'h1234, Req1_Data = 16'h5678;
  logic        DtackFromDram_L = 1'b1;
  logic        Req0_Dtack_L, Req1_Dtack_L, Req0_BErr_L, Req1_BErr_L;
  logic        AS_Dram_L, WE_Dram_L, UDS_Dram_L, LDS_Dram_L;
  logic [31:0] Address_Dram;
  logic [15:0] Data_Dram;
  logic [1:0]  Grant;
  logic [2:0]  ArbState;
  assign Req0_AS_L = en0 ? ag0 : man0;
  assign Req1_AS_L = en1 ? ag1 : man1;
  dram_port_arbiter #(.MAX_HOLD(MAX_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .Clock(clk), .Reset_H(rst),
    .Req0_AS_L(Req0_AS_L), .Req0_WE_L(Req0_WE_L), .Req0_UDS_L(Req0_UDS_L), .Req0_LDS_L(Req0_LDS_L),
    .Req0_Address(Req0_Address), .Req0_Data(Req0_Data),
    .Req1_AS_L(Req1_AS_L), .Req1_WE_L(Req1_WE_L), .Req1_UDS_L(Req1_UDS_L), .Req1_LDS_L(Req1_LDS_L),
    .Req1_Address(Req1_Address), .Req1_Data(Req1_Data),
    .Req0_Dtack_L(Req0_Dtack_L), .Req1_Dtack_L(Req1_Dtack_L),
    .Req0_BErr_L(Req0_BErr_L), .Req1_BErr_L(Req1_BErr_L),
    .AS_Dram_L(AS_Dram_L), .WE_Dram_L(WE_Dram_L), .UDS_Dram_L(UDS_Dram_L), .LDS_Dram_L(LDS_Dram_L),
    .Address_Dram(Address_Dram), .Data_Dram(Data_Dram),
    .DtackFromDram_L(DtackFromDram_L), .Grant(Grant), .ArbState(ArbState)
  );
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // requester agents: assert AS, drop it after seeing Dtack/BErr, re-request after one high cycle
  always @(negedge clk) begin
    seen0 = !Req0_Dtack_L || !Req0_BErr_L;
    seen1 = !Req1_Dtack_L || !Req1_BErr_L;
  end
  always @(posedge clk) begin
    #1;
    ag0 = !en0 || (!ag0 && seen0);
    ag1 = !en1 || (!ag1 && seen1);
  end
  // DRAM controller: acknowledges rsp_lat cycles into a continuous AS_Dram_L low stretch
  logic rsp_en = 1'b1, rsp_force = 1'b0;
  int   rsp_lat = 3, rsp_cnt = 0;
  always @(posedge clk) begin
    #2;
    rsp_cnt = AS_Dram_L ? 0 : rsp_cnt + 1;
    DtackFromDram_L = !(rsp_force || (rsp_en && !AS_Dram_L && rsp_cnt >= rsp_lat));
  end
  // reference model: who owns the port and where the access stands
  int m_phase = P_FREE, m_owner = 0, m_cyc = 0, m_streak = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_FREE;
      m_streak = 0;
    end else
      case (m_phase)
        P_FREE:
          if (!Req0_AS_L || !Req1_AS_L) begin
            m_owner = (!Req0_AS_L && (Req1_AS_L || m_streak < MAX_HOLD)) ? 0 : 1;
            m_streak = (m_owner == 0 && !Req1_AS_L) ? m_streak + 1 : 0;
            m_phase = P_ACC;
            m_cyc = 1;
          end
        P_ACC: begin
          if ((m_owner ? Req1_AS_L : Req0_AS_L)) m_phase = P_GAP;
          else if (!DtackFromDram_L) m_phase = P_DONE;
          else if (m_cyc == TIMEOUT) m_phase = P_ABT;
          else m_cyc++;
        end
        P_DONE, P_ABT: if ((m_owner ? Req1_AS_L : Req0_AS_L)) m_phase = P_GAP;
        default: m_phase = P_FREE;
      endcase
  end
  always @(negedge clk) begin
    logic busy, oas, ack, be;
    busy = m_phase == P_ACC || m_phase == P_DONE || m_phase == P_ABT;
    oas  = m_owner ? Req1_AS_L : Req0_AS_L;
    ack  = m_phase == P_ACC && !oas && !DtackFromDram_L;
    be   = m_phase == P_ACC && !oas && DtackFromDram_L && m_cyc == TIMEOUT;
    chk("cmp_grant", Grant, busy ? (m_owner ? 2 : 1) : 0);
    chk("cmp_as_dram", AS_Dram_L, !((m_phase == P_ACC && !oas && !be) || m_phase == P_DONE));
    chk("cmp_dtack0", Req0_Dtack_L, !((ack || m_phase == P_DONE) && m_owner == 0));
    chk("cmp_dtack1", Req1_Dtack_L, !((ack || m_phase == P_DONE) && m_owner == 1));
    chk("cmp_berr0", Req0_BErr_L, !((be || m_phase == P_ABT) && m_owner == 0));
    chk("cmp_berr1", Req1_BErr_L, !((be || m_phase == P_ABT) && m_owner == 1));
    chk("cmp_we", WE_Dram_L, busy ? (m_owner ? Req1_WE_L : Req0_WE_L) : 1'b1);
    chk("cmp_uds", UDS_Dram_L, busy ? (m_owner ? Req1_UDS_L : Req0_UDS_L) : 1'b1);
    chk("cmp_lds", LDS_Dram_L, busy ? (m_owner ? Req1_LDS_L : Req0_LDS_L) : 1'b1);
    chk("cmp_addr", Address_Dram, (busy && m_owner == 1) ? Req1_Address : Req0_Address);
    chk("cmp_data", Data_Dram, (busy && m_owner == 1) ? Req1_Data : Req0_Data);
    chk("one_dtack", Req0_Dtack_L | Req1_Dtack_L, 1);
  end
  // grant sequence observed on the DUT
  int grants[$];
  logic [1:0] prev_grant = 2'b00;
  always @(negedge clk) begin
    if (Grant != 2'b00 && prev_grant == 2'b00) grants.push_back(Grant == 2'b10 ? 1 : 0);
    prev_grant = Grant;
  end
  task automatic wait_grant(input logic [1:0] g);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (Grant !== g && k < 20);
    chk("grant_seen", Grant, g);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", Grant, 0);
    chk("rst_as", AS_Dram_L, 1);
    chk("rst_we", WE_Dram_L, 1);
    chk("rst_dtack0", Req0_Dtack_L, 1);
    chk("rst_berr1", Req1_BErr_L, 1);
    @(posedge clk); #1 rst = 1'b0;
    // req0 read alone, DRAM latency 3
    @(posedge clk); #1 man0 = 1'b0;
    @(negedge clk);
    chk("r32_idle_as", AS_Dram_L, 1);
    @(negedge clk);
    chk("r32_grant", Grant, 1);
    chk("r32_as", AS_Dram_L, 0);
    chk("r32_dtack_c1", Req0_Dtack_L, 1);
    @(negedge clk);
    chk("r32_dtack_c2", Req0_Dtack_L, 1);
    @(negedge clk);
    chk("r32_dram_dtack", DtackFromDram_L, 0);
    chk("r32_dtack_c3", Req0_Dtack_L, 0);
    @(posedge clk); #1 man0 = 1'b1;
    @(negedge clk);
    chk("r32_wait_dtack", Req0_Dtack_L, 0);
    chk("r32_wait_as", AS_Dram_L, 0);
    @(negedge clk);
    chk("r32_gap_grant", Grant, 0);
    chk("r32_gap_as", AS_Dram_L, 1);
    chk("r32_gap_dtack", Req0_Dtack_L, 1);
    @(negedge clk);
    chk("r32_idle_grant", Grant, 0);
    // req1 write
    @(posedge clk); #1;
    Req1_WE_L = 1'b0; Req1_UDS_L = 1'b0; Req1_LDS_L = 1'b0;
    Req1_Address = 32'h00F0_0010; Req1_Data = 16'hA5A5; man1 = 1'b0;
    wait_grant(2);
    chk("r34_addr", Address_Dram, 32'h00F0_0010);
    chk("r34_data", Data_Dram, 16'hA5A5);
    chk("r34_we", WE_Dram_L, 0);
    chk("r34_uds", UDS_Dram_L, 0);
    chk("r34_lds", LDS_Dram_L, 0);
    for (int k = 0; k < 10 && Req1_Dtack_L; k++) @(negedge clk);
    chk("r34_dtack1", Req1_Dtack_L, 0);
    chk("r34_dtack0", Req0_Dtack_L, 1);
    @(posedge clk); #1 man1 = 1'b1; Req1_WE_L = 1'b1;
    repeat (3) @(negedge clk);
    // both requesting continuously
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; rsp_lat = 1; grants.delete(); en0 = 1'b1; en1 = 1'b1;
    for (int k = 0; k < 300 && grants.size() < 10; k++) @(negedge clk);
    chk("r33_count", grants.size() >= 10, 1);
    for (int i = 0; i < 10 && i < grants.size(); i++) chk($sformatf("r33_seq%0d", i), grants[i], exp_seq[i]);
    @(posedge clk); #1 en0 = 1'b0; en1 = 1'b0;
    repeat (4) @(negedge clk);
    // timeout abort
    rsp_en = 1'b0; rsp_lat = 3;
    @(posedge clk); #1 en0 = 1'b1;
    wait_grant(1);
    repeat (253) @(negedge clk);
    chk("r35_berr_c254", Req0_BErr_L, 1);
    chk("r35_as_c254", AS_Dram_L, 0);
    @(negedge clk);
    chk("r35_berr_c255", Req0_BErr_L, 0);
    chk("r35_as_c255", AS_Dram_L, 1);
    chk("r35_dtack_c255", Req0_Dtack_L, 1);
    @(negedge clk);
    chk("r35_wait_berr", Req0_BErr_L, 0);
    chk("r35_wait_as", AS_Dram_L, 1);
    en0 = 1'b0;
    @(negedge clk);
    chk("r35_gap_grant", Grant, 0);
    chk("r35_gap_berr", Req0_BErr_L, 1);
    @(negedge clk);
    chk("r35_idle_grant", Grant, 0);
    rsp_en = 1'b1;
    // reset during Own1 with Dtack pending
    @(posedge clk); #1 en1 = 1'b1;
    wait_grant(2);
    #1 rst = 1'b1;
    #1;
    chk("r36_grant", Grant, 0);
    chk("r36_as", AS_Dram_L, 1);
    chk("r36_dtack1", Req1_Dtack_L, 1);
    chk("r36_berr1", Req1_BErr_L, 1);
    en1 = 1'b0; rsp_force = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("r36_late_dtack", Req1_Dtack_L, 1);
      chk("r36_late_grant", Grant, 0);
    end
    rsp_force = 1'b0;
    repeat (2) @(negedge clk);
    // req0 abandons before Dtack
    rsp_en = 1'b0;
    @(posedge clk); #1 man0 = 1'b0;
    wait_grant(1);
    #1 man0 = 1'b1;
    #1;
    chk("r37_as", AS_Dram_L, 1);
    chk("r37_dtack", Req0_Dtack_L, 1);
    @(negedge clk);
    chk("r37_gap_grant", Grant, 0);
    chk("r37_gap_dtack", Req0_Dtack_L, 1);
    @(negedge clk);
    chk("r37_idle_grant", Grant, 0);
    chk("r37_idle_as", AS_Dram_L, 1);
    rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
